// File: rtl/hs_npu_mem_arbiter_if.sv
// Bundle between the NPU requesters, the memory arbiter and the burst memory interface.
// The arbiter takes the slave modport; requesters and memory together take the master modport.
interface hs_npu_mem_arbiter_if #(
  parameter int NUM_RD      = 2,
  parameter int BURST_WORDS = 2
);
  // Handshakes: rd_req_i/wr_req_i are levels held until the matching one-cycle done/err pulse.
  // mem_ready_i gates arbitration. mem_read_ready_o stays high from issue until the burst lands.
  // mem_valid_i is a one-cycle completion strobe. mem_write_valid_o is a one-cycle issue strobe,
  // and a write completes when mem_ready_i goes low and then high again.
  logic [NUM_RD-1:0]                 rd_req_i;
  logic [NUM_RD-1:0][31:0]           rd_addr_i;
  logic [NUM_RD-1:0]                 rd_done_o;
  logic [NUM_RD-1:0]                 rd_err_o;
  logic [BURST_WORDS-1:0][31:0]      rd_data_o;
  logic                              wr_req_i;
  logic [31:0]                       wr_addr_i;
  logic [BURST_WORDS-1:0][31:0]      wr_data_i;
  logic                              wr_done_o;
  logic                              mem_ready_i;
  logic                              mem_valid_i;
  logic [BURST_WORDS-1:0][31:0]      mem_data_i;
  logic                              mem_read_ready_o;
  logic                              mem_write_valid_o;
  logic                              mem_invalidate_o;
  logic [31:0]                       mem_addr_o;
  logic [BURST_WORDS-1:0][31:0]      mem_wdata_o;

  modport slave (
    input  rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i,
           mem_ready_i, mem_valid_i, mem_data_i,
    output rd_done_o, rd_err_o, rd_data_o, wr_done_o,
           mem_read_ready_o, mem_write_valid_o, mem_invalidate_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i,
           mem_ready_i, mem_valid_i, mem_data_i,
    input  rd_done_o, rd_err_o, rd_data_o, wr_done_o,
           mem_read_ready_o, mem_write_valid_o, mem_invalidate_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/hs_npu_mem_arbiter.sv
// Shares one burst memory port between NUM_RD round-robin readers and a priority writer.
// Hung reads are invalidated after TIMEOUT cycles in RD_WAIT.
module hs_npu_mem_arbiter #(
  parameter int NUM_RD      = 2,
  parameter int BURST_WORDS = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  hs_npu_mem_arbiter_if.slave bus,
  output logic [2:0]          dbg_state
);
  localparam int IDX_W = (NUM_RD > 2) ? 2 : 1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT);
  localparam logic [NUM_RD-1:0] ONE_HOT0 = NUM_RD'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    WR_WAIT  = 3'd4,
    RD_ABORT = 3'd5
  } state_t;

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             rr_q;
  logic [IDX_W-1:0]             idx_q;
  logic [31:0]                  addr_q;
  logic [BURST_WORDS-1:0][31:0] wdata_q;
  logic [BURST_WORDS-1:0][31:0] rd_data_q;
  logic [7:0]                   cnt_q;
  logic                         seen_low_q;
  logic [NUM_RD-1:0]            rd_done_q;
  logic                         wr_done_q;

  logic                         rd_any;
  logic [IDX_W-1:0]             rd_pick;
  logic                         grant_wr;
  logic                         grant_rd;
  logic                         timeout_hit;

  function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_RD) s = s - NUM_RD;
    return IDX_W'(s);
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_RD - 1)) ? '0 : i + 1'b1;
  endfunction

  // Scan downward so the requester closest to rr_q (at or after it) is the last assignment.
  always_comb begin
    rd_any  = 1'b0;
    rd_pick = rr_q;
    for (int k = NUM_RD - 1; k >= 0; k--) begin
      if (bus.rd_req_i[rot_idx(rr_q, k)]) begin
        rd_any  = 1'b1;
        rd_pick = rot_idx(rr_q, k);
      end
    end
  end

  assign grant_wr    = (state_q == IDLE) && bus.mem_ready_i && bus.wr_req_i;
  assign grant_rd    = (state_q == IDLE) && bus.mem_ready_i && !bus.wr_req_i && rd_any;
  assign timeout_hit = (cnt_q + 8'd1) == TO_LAST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_wr)      state_d = WR_ISSUE;
        else if (grant_rd) state_d = RD_ISSUE;
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        // Data arriving on the timeout cycle still completes the read.
        if (bus.mem_valid_i)  state_d = IDLE;
        else if (timeout_hit) state_d = RD_ABORT;
      end
      RD_ABORT: state_d = IDLE;
      WR_ISSUE: state_d = WR_WAIT;
      WR_WAIT:  if (bus.mem_ready_i && seen_low_q) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      cnt_q      <= '0;
      seen_low_q <= 1'b0;
      rd_done_q  <= '0;
      wr_done_q  <= 1'b0;
    end else begin
      rd_done_q <= '0;
      wr_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_wr) begin
            addr_q  <= bus.wr_addr_i;
            wdata_q <= bus.wr_data_i;
          end else if (grant_rd) begin
            idx_q  <= rd_pick;
            addr_q <= bus.rd_addr_i[rd_pick];
          end
        end
        RD_ISSUE: cnt_q <= '0;
        RD_WAIT: begin
          if (bus.mem_valid_i) begin
            rd_data_q <= bus.mem_data_i;
            rd_done_q <= ONE_HOT0 << idx_q;
            rr_q      <= next_idx(idx_q);
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RD_ABORT: rr_q <= next_idx(idx_q);
        WR_ISSUE: seen_low_q <= 1'b0;
        WR_WAIT: begin
          // Completion needs a low-then-high on mem_ready_i seen while waiting.
          if (!bus.mem_ready_i)    seen_low_q <= 1'b1;
          else if (seen_low_q)     wr_done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.mem_read_ready_o  = (state_q == RD_ISSUE) || (state_q == RD_WAIT);
    bus.mem_write_valid_o = (state_q == WR_ISSUE);
    bus.mem_invalidate_o  = (state_q == RD_ABORT);
    bus.rd_err_o          = (state_q == RD_ABORT) ? (ONE_HOT0 << idx_q) : '0;
    bus.rd_done_o         = rd_done_q;
    bus.rd_data_o         = rd_data_q;
    bus.wr_done_o         = wr_done_q;
    bus.mem_addr_o        = addr_q;
    bus.mem_wdata_o       = wdata_q;
    dbg_state             = state_q;
  end
endmodule

// File: tb/tb_hs_npu_mem_arbiter.sv
// Randomised bench for hs_npu_mem_arbiter: requesters and a burst memory model drive the DUT,
// a transaction-level arbitration model predicts every completion for a scoreboard queue.
module tb_hs_npu_mem_arbiter;
  localparam int NUM_RD = 2;
  localparam int BW     = 2;
  localparam int TO     = 8;
  localparam int DW     = BW * 32;
  localparam int EW     = 2 + 2 + 32 + 32 + DW;
  localparam logic [1:0] K_DONE = 2'd0;
  localparam logic [1:0] K_ERR  = 2'd1;
  localparam logic [1:0] K_WR   = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  logic [EW-1:0] exp_q[$];

  hs_npu_mem_arbiter_if #(.NUM_RD(NUM_RD), .BURST_WORDS(BW)) bus ();

  hs_npu_mem_arbiter #(.NUM_RD(NUM_RD), .BURST_WORDS(BW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // stimulus / memory model state
  int   rd_left;
  int   wr_left;
  bit   auto_on;
  int   model_rr;
  bit   mem_pend;
  int   mem_cd;
  int   wr_cd;
  bit   force_hi;
  int   force_l;
  logic prev_mrr;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] memf(input logic [31:0] a);
    logic [DW-1:0] r;
    r = '0;
    for (int w = 0; w < BW; w++) r[w*32 +: 32] = (a ^ 32'hC3C3_0000) + 32'(w * 7 + 1);
    return r;
  endfunction

  // Called at the negedge of the cycle in which the DUT first presents a request to memory.
  // Inputs still hold the values the DUT sampled when it made the grant.
  task automatic on_issue(input bit is_wr);
    int          e_idx;
    int          l;
    int          d;
    logic [31:0] ea;
    chk("grant_ready", {127'd0, bus.mem_ready_i}, 128'd1);
    chk("grant_kind", {126'd0, is_wr, bus.wr_req_i | (|bus.rd_req_i)}, {126'd0, bus.wr_req_i, 1'b1});
    if (is_wr) begin
      d = $urandom_range(2, 5);
      wr_cd = d;
      exp_q.push_back({K_WR, 2'd0, 32'(cyc + d + 1), bus.wr_addr_i, bus.wr_data_i});
    end else begin
      e_idx = model_rr;
      for (int k = 0; k < NUM_RD; k++) begin
        if (bus.rd_req_i[(model_rr + k) % NUM_RD]) begin
          e_idx = (model_rr + k) % NUM_RD;
          break;
        end
      end
      model_rr = (e_idx + 1) % NUM_RD;
      ea = bus.rd_addr_i[e_idx];
      if (force_l > 0) l = force_l;
      else begin
        case ($urandom_range(0, 9))
          0:       l = TO;
          1:       l = TO + 1;
          2:       l = 100000;
          default: l = $urandom_range(1, TO - 1);
        endcase
      end
      bus.mem_data_i = memf(bus.mem_addr_o);
      mem_pend = 1'b1;
      mem_cd = l;
      if (l <= TO) exp_q.push_back({K_DONE, 2'(e_idx), 32'(cyc + l + 1), ea, memf(ea)});
      else         exp_q.push_back({K_ERR, 2'(e_idx), 32'(cyc + TO + 1), ea, {DW{1'b0}}});
    end
  endtask

  task automatic step();
    @(negedge clk);
    bus.mem_valid_i = 1'b0;
    if (mem_pend) begin
      mem_cd--;
      if (mem_cd == 0) begin
        bus.mem_valid_i = 1'b1;
        mem_pend = 1'b0;
      end
    end
    if (bus.mem_invalidate_o) mem_pend = 1'b0;
    if (bus.mem_read_ready_o && !prev_mrr) on_issue(1'b0);
    if (bus.mem_write_valid_o) on_issue(1'b1);
    prev_mrr = bus.mem_read_ready_o;
    if (wr_cd > 0) begin
      bus.mem_ready_i = 1'b0;
      wr_cd--;
      if (wr_cd == 0) force_hi = 1'b1;
    end else if (force_hi) begin
      bus.mem_ready_i = 1'b1;
      force_hi = 1'b0;
    end else begin
      bus.mem_ready_i = ($urandom_range(0, 4) != 0);
    end
    for (int i = 0; i < NUM_RD; i++) begin
      if (bus.rd_done_o[i] || bus.rd_err_o[i]) bus.rd_req_i[i] = 1'b0;
      else if (auto_on && !bus.rd_req_i[i] && rd_left > 0 && $urandom_range(0, 2) == 0) begin
        bus.rd_req_i[i]  = 1'b1;
        bus.rd_addr_i[i] = $urandom() & 32'hFFFF_FFC0;
        rd_left--;
      end
    end
    if (bus.wr_done_o) bus.wr_req_i = 1'b0;
    else if (auto_on && !bus.wr_req_i && wr_left > 0 && $urandom_range(0, 5) == 0) begin
      bus.wr_req_i  = 1'b1;
      bus.wr_addr_i = $urandom() & 32'hFFFF_FFC0;
      for (int w = 0; w < BW; w++) bus.wr_data_i[w] = $urandom();
      wr_left--;
    end
  endtask

  // monitor: pops one expectation per completion pulse
  logic [EW-1:0] m_e;
  logic [1:0]    m_kind;
  logic [1:0]    m_act_kind;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_invalidate_o)
        chk("inv_with_err", {126'd0, bus.mem_read_ready_o, |bus.rd_err_o}, 128'd1);
      if ((|bus.rd_done_o) || (|bus.rd_err_o) || bus.wr_done_o) begin
        if (exp_q.size() == 0) begin
          chk("spurious_completion", {123'd0, bus.wr_done_o, bus.rd_done_o, bus.rd_err_o}, 128'd0);
        end else begin
          m_e = exp_q.pop_front();
          m_kind = m_e[EW-1 -: 2];
          m_act_kind = bus.wr_done_o ? K_WR : ((|bus.rd_err_o) ? K_ERR : K_DONE);
          chk("kind", {126'd0, m_act_kind}, {126'd0, m_kind});
          chk("cycle", 128'(cyc), {96'd0, m_e[EW-5 -: 32]});
          if (m_kind == K_WR) begin
            chk("wr_addr", {96'd0, bus.mem_addr_o}, {96'd0, m_e[DW+31 -: 32]});
            chk("wr_data", {64'd0, bus.mem_wdata_o}, {64'd0, m_e[DW-1:0]});
          end else if (m_kind == K_DONE) begin
            chk("rd_done_idx", {126'd0, bus.rd_done_o}, 128'(1) << m_e[EW-3 -: 2]);
            chk("rd_data", {64'd0, bus.rd_data_o}, {64'd0, m_e[DW-1:0]});
          end else begin
            chk("rd_err_idx", {126'd0, bus.rd_err_o}, 128'(1) << m_e[EW-3 -: 2]);
            chk("err_inv", {126'd0, bus.mem_invalidate_o, bus.mem_read_ready_o}, 128'd2);
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, {116'd0, bus.rd_done_o, bus.rd_err_o, bus.wr_done_o, bus.mem_read_ready_o,
                        bus.mem_write_valid_o, bus.mem_invalidate_o, dbg_state}, 128'd0);
    chk({tag, "_rdata"}, {64'd0, bus.rd_data_o}, 128'd0);
    chk({tag, "_addr_wdata"}, {32'd0, bus.mem_addr_o, bus.mem_wdata_o}, 128'd0);
  endtask

  int guard;
  initial begin
    bus.rd_req_i    = '0;
    bus.rd_addr_i   = '0;
    bus.wr_req_i    = 1'b0;
    bus.wr_addr_i   = '0;
    bus.wr_data_i   = '0;
    bus.mem_ready_i = 1'b1;
    bus.mem_valid_i = 1'b0;
    bus.mem_data_i  = '0;
    rd_left = 60; wr_left = 16; auto_on = 1'b1; model_rr = 0;
    mem_pend = 1'b0; mem_cd = 0; wr_cd = 0; force_hi = 1'b0; force_l = 0; prev_mrr = 1'b0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    guard = 0;
    while (!(rd_left == 0 && wr_left == 0 && exp_q.size() == 0 && bus.rd_req_i == '0 && !bus.wr_req_i)
           && guard < 20000) begin
      step();
      guard++;
    end
    chk("random_drain", {127'd0, guard < 20000}, 128'd1);

    // Move the round-robin pointer off zero, then reset while requester 1 sits in RD_WAIT.
    auto_on = 1'b0;
    repeat (3) step();
    force_l = 3;
    bus.rd_addr_i[0] = 32'h0000_0100;
    bus.rd_req_i[0]  = 1'b1;
    guard = 0;
    while (bus.rd_req_i[0] && guard < 200) begin step(); guard++; end
    chk("dir_read0_drain", {127'd0, guard < 200}, 128'd1);

    force_l = 100000;
    bus.rd_addr_i[1] = 32'h0000_0200;
    bus.rd_req_i[1]  = 1'b1;
    step();
    bus.rd_addr_i[0] = 32'h0000_0300;
    bus.rd_req_i[0]  = 1'b1;
    guard = 0;
    while (!bus.mem_read_ready_o && guard < 200) begin step(); guard++; end
    chk("dir_issue", {127'd0, guard < 200}, 128'd1);
    step();
    step();
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    exp_q.delete();
    model_rr = 0; mem_pend = 1'b0; prev_mrr = 1'b0; wr_cd = 0; force_hi = 1'b0;
    bus.mem_valid_i = 1'b0;
    force_l = 3;
    @(negedge clk);
    rst_n = 1'b1;
    guard = 0;
    while ((bus.rd_req_i != '0 || exp_q.size() != 0) && guard < 500) begin step(); guard++; end
    chk("post_reset_drain", {127'd0, guard < 500}, 128'd1);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
